// File: rtl/car_pkg.sv
// Shared definitions for the car chassis control blocks: FSM state and turn
// direction encodings, default turn timings and trigger bit positions.
package car_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        TURN   = 2'b01,
        SETTLE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_BACK  = 2'b10
    } dir_t;

    // Default timings at the 500 Hz system clock, also used by the semi-auto generator
    localparam int DEFAULT_TURN_90_CYCLES  = 450;
    localparam int DEFAULT_TURN_180_CYCLES = 900;
    localparam int DEFAULT_SETTLE_CYCLES   = 25;

    // Bit positions of the turn triggers in the packed trigger vector
    localparam int TRIG_LEFT  = 0;
    localparam int TRIG_RIGHT = 1;
    localparam int TRIG_BACK  = 2;

    // Resolves simultaneous rises: back wins over left, left wins over right
    function automatic dir_t pick_dir(input logic [2:0] rise);
        if (rise[TRIG_BACK])
            return DIR_BACK;
        else if (rise[TRIG_LEFT])
            return DIR_LEFT;
        else
            return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Per-bit rising-edge detector. The previous value is registered every cycle
// regardless of any enable, so a level that stays high never produces a
// second rise.
module rise_detect #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] trig,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev;

    // Remember last cycle's trigger levels; cleared by reset so a level already high counts as a rise
    always_ff @(posedge clk) begin
        if (!rst_n)
            prev <= '0;
        else
            prev <= trig;
    end

    assign rise = trig & ~prev;

endmodule

// File: rtl/turn_executor.sv
// Turn executor: accepts one-shot turn triggers while idle, drives the motor
// direction for a fixed number of cycles, waits a settle period, then pulses
// turn_done. Forward motion is gated off whenever a turn is in progress.
module turn_executor
    import car_pkg::*;
#(
    parameter int TURN_90_CYCLES  = DEFAULT_TURN_90_CYCLES,
    parameter int TURN_180_CYCLES = DEFAULT_TURN_180_CYCLES,
    parameter int SETTLE_CYCLES   = DEFAULT_SETTLE_CYCLES,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic trigger_turn_left,
    input  logic trigger_turn_right,
    input  logic trigger_turn_back,
    input  logic in_move_forward,
    output logic is_turning,
    output logic turn_left,
    output logic turn_right,
    output logic move_forward,
    output logic turn_done
);

    state_t           state;
    dir_t             dir;
    dir_t             new_dir;
    logic [CNT_W-1:0] count;
    logic [2:0]       trig;
    logic [2:0]       rise;
    logic             accepted_rise;

    assign trig[TRIG_LEFT]  = trigger_turn_left;
    assign trig[TRIG_RIGHT] = trigger_turn_right;
    assign trig[TRIG_BACK]  = trigger_turn_back;

    rise_detect #(
        .WIDTH(3)
    ) u_rise_detect (
        .clk  (clk),
        .rst_n(rst_n),
        .trig (trig),
        .rise (rise)
    );

    assign accepted_rise = (state == IDLE) & enable & (|rise);
    assign new_dir       = pick_dir(rise);

    // Turn sequencer: state, down-counter, latched direction and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            dir          <= DIR_LEFT;
            count        <= '0;
            is_turning   <= 1'b0;
            turn_left    <= 1'b0;
            turn_right   <= 1'b0;
            move_forward <= 1'b0;
            turn_done    <= 1'b0;
        end else begin
            turn_done    <= 1'b0;
            move_forward <= in_move_forward & enable & (state == IDLE) & ~accepted_rise;
            if (!enable) begin
                state      <= IDLE;
                count      <= '0;
                is_turning <= 1'b0;
                turn_left  <= 1'b0;
                turn_right <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accepted_rise) begin
                            state      <= TURN;
                            dir        <= new_dir;
                            count      <= (new_dir == DIR_BACK) ? CNT_W'(TURN_180_CYCLES - 1)
                                                                : CNT_W'(TURN_90_CYCLES - 1);
                            is_turning <= 1'b1;
                            turn_left  <= (new_dir != DIR_RIGHT);
                            turn_right <= (new_dir == DIR_RIGHT);
                        end
                    end
                    TURN: begin
                        if (count == '0) begin
                            state      <= SETTLE;
                            count      <= CNT_W'(SETTLE_CYCLES - 1);
                            turn_left  <= 1'b0;
                            turn_right <= 1'b0;
                        end else begin
                            count      <= count - CNT_W'(1);
                            turn_left  <= (dir != DIR_RIGHT);
                            turn_right <= (dir == DIR_RIGHT);
                        end
                    end
                    SETTLE: begin
                        if (count == '0) begin
                            state      <= IDLE;
                            is_turning <= 1'b0;
                            turn_done  <= 1'b1;
                        end else begin
                            count <= count - CNT_W'(1);
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        count      <= '0;
                        is_turning <= 1'b0;
                        turn_left  <= 1'b0;
                        turn_right <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_turn_executor.sv
// Bench for turn_executor: directed table of multi-cycle sequences with
// hand-derived expected outputs, followed by randomized stimulus. Every cycle
// is also compared against a timestamp-based reference model of turn timing.
module tb_turn_executor;

    localparam int T90    = 450;
    localparam int T180   = 900;
    localparam int SETTLE = 25;

    logic clk;
    logic rst_n;
    logic enable;
    logic trigger_turn_left;
    logic trigger_turn_right;
    logic trigger_turn_back;
    logic in_move_forward;
    logic is_turning;
    logic turn_left;
    logic turn_right;
    logic move_forward;
    logic turn_done;

    int tests_run;
    int tests_failed;

    // Reference model: a turn is described by its start cycle, its length and direction
    int         cyc;
    logic [2:0] m_prev;
    bit         m_active;
    bit         m_right;
    int         m_start;
    int         m_dur;
    logic [4:0] m_exp;

    typedef struct {
        string      name;
        bit         rst_n;
        bit         en;
        bit         back;
        bit         right;
        bit         left;
        bit         mf;
        int         cycles;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[31];

    turn_executor dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable            (enable),
        .trigger_turn_left (trigger_turn_left),
        .trigger_turn_right(trigger_turn_right),
        .trigger_turn_back (trigger_turn_back),
        .in_move_forward   (in_move_forward),
        .is_turning        (is_turning),
        .turn_left         (turn_left),
        .turn_right        (turn_right),
        .move_forward      (move_forward),
        .turn_done         (turn_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model across one clock edge using the inputs currently applied
    task automatic modelStep();
        logic [2:0] trig_now;
        logic [2:0] rises;
        bit idle;
        bit e_done;
        bit e_mf;
        int e;
        trig_now = {trigger_turn_back, trigger_turn_right, trigger_turn_left};
        rises    = trig_now & ~m_prev;
        cyc++;
        e_done = 1'b0;
        e_mf   = 1'b0;
        if (!rst_n) begin
            m_prev   = 3'b000;
            m_active = 1'b0;
        end else begin
            m_prev = trig_now;
            if (!enable) begin
                m_active = 1'b0;
            end else begin
                idle = !m_active;
                if (m_active && (cyc - m_start == m_dur + SETTLE)) begin
                    m_active = 1'b0;
                    e_done   = 1'b1;
                end
                e_mf = in_move_forward && idle && (rises == 3'b000);
                if (idle && rises != 3'b000) begin
                    m_active = 1'b1;
                    m_start  = cyc;
                    m_dur    = rises[2] ? T180 : T90;
                    m_right  = !rises[2] && !rises[0];
                end
            end
        end
        e = cyc - m_start;
        m_exp = {m_active,
                 m_active && !m_right && (e < m_dur),
                 m_active &&  m_right && (e < m_dur),
                 e_mf,
                 e_done};
    endtask

    task automatic checkOutput(input string name, input logic [4:0] actual, input logic [4:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got {turning,left,right,fwd,done}=%b, want %b",
                     name, cyc, actual, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and check the outputs after the rising edge
    task automatic driveCycle(input bit r, input bit en, input bit b, input bit rt, input bit l, input bit mf);
        @(negedge clk);
        rst_n              = r;
        enable             = en;
        trigger_turn_back  = b;
        trigger_turn_right = rt;
        trigger_turn_left  = l;
        in_move_forward    = mf;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("model", {is_turning, turn_left, turn_right, move_forward, turn_done}, m_exp);
    endtask

    task automatic applyStimulus(input vec_t v);
        for (int i = 0; i < v.cycles; i++)
            driveCycle(v.rst_n, v.en, v.back, v.right, v.left, v.mf);
        checkOutput(v.name, {is_turning, turn_left, turn_right, move_forward, turn_done}, v.exp);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        m_prev       = 3'b000;
        m_active     = 1'b0;
        m_right      = 1'b0;
        m_start      = 0;
        m_dur        = 0;
        m_exp        = 5'b00000;

        // name, rst_n, en, back, right, left, fwd, cycles, {turning,left,right,fwd,done}
        vecs[0]  = '{"reset",           0, 0, 0, 0, 0, 0,   2, 5'b00000};
        vecs[1]  = '{"idle_forward",    1, 1, 0, 0, 0, 1,   1, 5'b00010};
        vecs[2]  = '{"left_start",      1, 1, 0, 0, 1, 1,   1, 5'b11000};
        vecs[3]  = '{"left_held",       1, 1, 0, 0, 1, 1,   4, 5'b11000};
        vecs[4]  = '{"left_mid",        1, 1, 0, 0, 0, 1, 444, 5'b11000};
        vecs[5]  = '{"left_last",       1, 1, 0, 0, 0, 1,   1, 5'b11000};
        vecs[6]  = '{"left_settle",     1, 1, 0, 0, 0, 1,   1, 5'b10000};
        vecs[7]  = '{"left_settle_end", 1, 1, 0, 0, 0, 1,  24, 5'b10000};
        vecs[8]  = '{"left_done",       1, 1, 0, 0, 0, 1,   1, 5'b00001};
        vecs[9]  = '{"forward_resume",  1, 1, 0, 0, 0, 1,   1, 5'b00010};
        vecs[10] = '{"back_prio",       1, 1, 1, 1, 0, 0,   1, 5'b11000};
        vecs[11] = '{"back_last",       1, 1, 0, 0, 0, 0, 899, 5'b11000};
        vecs[12] = '{"back_settle",     1, 1, 0, 0, 0, 0,   1, 5'b10000};
        vecs[13] = '{"back_done",       1, 1, 0, 0, 0, 0,  25, 5'b00001};
        vecs[14] = '{"abort_start",     1, 1, 0, 0, 1, 0,   1, 5'b11000};
        vecs[15] = '{"abort_run",       1, 1, 0, 0, 1, 0, 199, 5'b11000};
        vecs[16] = '{"abort_disable",   1, 0, 0, 0, 1, 0,   1, 5'b00000};
        vecs[17] = '{"reenable_held",   1, 1, 0, 0, 1, 0,   3, 5'b00000};
        vecs[18] = '{"trig_release",    1, 1, 0, 0, 0, 0,   1, 5'b00000};
        vecs[19] = '{"fresh_rise",      1, 1, 0, 0, 1, 0,   1, 5'b11000};
        vecs[20] = '{"into_settle",     1, 1, 0, 0, 0, 0, 460, 5'b10000};
        vecs[21] = '{"reset_settle",    0, 1, 0, 0, 1, 0,   1, 5'b00000};
        vecs[22] = '{"held_thru_reset", 1, 1, 0, 0, 1, 0,   1, 5'b11000};
        vecs[23] = '{"post_reset_run",  1, 1, 0, 0, 0, 0, 474, 5'b10000};
        vecs[24] = '{"post_reset_done", 1, 1, 0, 0, 0, 0,   1, 5'b00001};
        vecs[25] = '{"ign_start",       1, 1, 0, 0, 1, 0,   1, 5'b11000};
        vecs[26] = '{"ign_run",         1, 1, 0, 0, 0, 0,  99, 5'b11000};
        vecs[27] = '{"ign_right_rise",  1, 1, 0, 1, 0, 0,   1, 5'b11000};
        vecs[28] = '{"ign_left_last",   1, 1, 0, 0, 0, 0, 349, 5'b11000};
        vecs[29] = '{"ign_done",        1, 1, 0, 0, 0, 0,  26, 5'b00001};
        vecs[30] = '{"no_second_turn",  1, 1, 0, 0, 0, 0,  50, 5'b00000};

        for (int i = 0; i < 31; i++)
            applyStimulus(vecs[i]);

        // Randomized traffic: sparse trigger edges, occasional disable and reset
        begin
            bit r, en, b, rt, l, mf;
            r = 1'b1; en = 1'b1; b = 1'b0; rt = 1'b0; l = 1'b0; mf = 1'b0;
            for (int i = 0; i < 12000; i++) begin
                r  = ($urandom_range(0, 1999) != 0);
                en = ($urandom_range(0, 999) != 0) ? 1'b1 : ~en;
                if ($urandom_range(0, 99) < 2) b  = ~b;
                if ($urandom_range(0, 99) < 3) rt = ~rt;
                if ($urandom_range(0, 99) < 3) l  = ~l;
                if ($urandom_range(0, 99) < 5) mf = ~mf;
                driveCycle(r, en, b, rt, l, mf);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/turn_executor.md
# turn_executor

Executes turn commands for the car chassis. Takes the one-shot turn triggers and the forward request from the semi-auto command generator, drives the left/right motor-direction commands for a fixed number of clock ticks, and reports `is_turning` back to the generator. Sits between the semi-auto command generator and the motor/LED output stage, on the same 500 Hz clock.

## Interface
**Parameters**
- `TURN_90_CYCLES`, default 450: cycles a left or right turn drives the motor (0.9 s at 500 Hz). Must be ≥1.
- `TURN_180_CYCLES`, default 900: cycles a back turn drives the motor. Must be ≥1.
- `SETTLE_CYCLES`, default 25: idle-motor cycles after a turn before `is_turning` drops. Must be ≥1.
- `CNT_W`, default 16: counter width. Must hold max(TURN_180_CYCLES, SETTLE_CYCLES).

**Ports**
- `clk` in 1: 500 Hz system clock. Single clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `enable` in 1: block active. Low aborts any turn.
- `trigger_turn_left` in 1: turn request, level held for several cycles.
- `trigger_turn_right` in 1: turn request.
- `trigger_turn_back` in 1: 180° turn request.
- `in_move_forward` in 1: forward request from the generator.
- `is_turning` out 1: high from turn start through the end of settle.
- `turn_left` out 1: motor command, rotate left.
- `turn_right` out 1: motor command, rotate right.
- `move_forward` out 1: gated forward command to the motors.
- `turn_done` out 1: one-cycle pulse on normal turn completion.

## Operation
- The block registers each trigger every cycle into `prev_*`, including while disabled. A rise is `trig & ~prev`. Only rises are accepted; a held level never retriggers.
- Rises are accepted only in IDLE with `enable=1`. Rises during TURN or SETTLE are ignored and are not queued.
- When several rises occur in the same cycle, priority is back > left > right.
- A back turn rotates left (`turn_left=1`) for TURN_180_CYCLES.
- State machine with states IDLE, TURN, SETTLE:
  - IDLE → TURN on an accepted rise. The block loads the counter with the duration minus 1 and latches the direction.
  - TURN: exactly one of `turn_left`/`turn_right` is high. The counter decrements each cycle. At 0 the block moves to SETTLE and loads SETTLE_CYCLES−1.
  - SETTLE: both turn outputs are low. At counter 0 the block moves to IDLE and pulses `turn_done`.
  - Any state with `enable=0` → IDLE on the next edge. All outputs go low and there is no `turn_done`.
- `move_forward` is the registered value of `in_move_forward & enable & (state==IDLE) & ~accepted_rise`. Forward motion and rotation are never concurrent.
- Reset (`rst_n=0` at an edge): state IDLE, counter 0, `prev_*` 0. Every output resets to 0. Reset mid-turn aborts the turn with no `turn_done`.
- Because `prev_*` resets to 0, a trigger already high on the first cycle after reset counts as a rise.

## Timing
- Rise sampled at edge N: at N+1, `is_turning=1` and the direction output is 1.
- Direction output is high for exactly TURN_*_CYCLES cycles, then low.
- `is_turning` is high for exactly TURN_*_CYCLES + SETTLE_CYCLES cycles.
- `turn_done` is high in the first cycle that `is_turning` is 0.
- `move_forward` has a latency of 1 cycle from `in_move_forward`. It is forced low in the same cycle `is_turning` rises.
- A new turn can start on the cycle after `turn_done`, provided a fresh rise occurs.

## Structure
- Shared package `car_pkg`:
  - 2-bit state encoding: IDLE=2'b00, TURN=2'b01, SETTLE=2'b10.
  - Direction encoding: DIR_LEFT, DIR_RIGHT, DIR_BACK.
  - Default cycle constants, reused by the semi-auto generator.
- Sub-module `rise_detect`: a per-bit registered rising-edge detector with synchronous active-low reset, instantiated 3 bits wide.
- Top level contains the FSM, the down-counter, and the output registers.

## Test plan
- Reset with all triggers low, then hold `trigger_turn_left` for 5 cycles → `turn_left` high for 450 cycles, `is_turning` high for 475 cycles, then a single `turn_done` pulse. The held trigger causes no retrigger.
- `trigger_turn_back` and `trigger_turn_right` rise in the same cycle → back turn: `turn_left` high for 900 cycles, `turn_right` stays 0.
- Rise `trigger_turn_right` at cycle 100 of an ongoing left turn → ignored. The left turn completes unchanged and no second turn follows.
- `in_move_forward=1` held; left rise at cycle 10 → `move_forward` 1 through cycle 10, 0 from cycle 11 until `is_turning` falls, 1 again one cycle after that.
- `enable` dropped at cycle 200 of a turn → all outputs 0 next cycle and no `turn_done`. Re-enable with the trigger still high → no turn until a fresh rise.
- `rst_n` asserted mid-SETTLE → all outputs 0 at the next edge. After release, a trigger held high across reset starts a turn one cycle later.
